// File: rtl/aes_sbox_pkg.sv
// AES S-box tables, per-byte lookup helpers and the lookup mode type.
package aes_sbox_pkg;

  typedef enum logic {SBOX_INV = 1'b0, SBOX_FWD = 1'b1} sbox_mode_e;

  localparam int unsigned MAX_BYTES  = 16;
  localparam int unsigned MAX_STAGES = 3;

  // Entry 0 sits in the leftmost literal, so TBL[b] is the substitute for byte b.
  localparam logic [0:255][7:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[b];
  endfunction

  // Four-lane inverse lookup kept for the older 32-bit decipher path.
  function automatic logic [31:0] sbox_inv_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = SBOX_INV_TBL[w[8*k +: 8]];
    return r;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of SubBytes/InvSubBytes; purely combinational.
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  sbox_mode_e  i_mode,
  input  logic [7:0]  i_byte,
  output logic [7:0]  o_byte
);

  always_comb begin
    o_byte = (i_mode == SBOX_FWD) ? sbox_fwd(i_byte) : sbox_inv(i_byte);
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Elastic pipelined SubBytes/InvSubBytes over NUM_BYTES lanes with valid/ready on both sides.
module sub_bytes_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 4,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  localparam int unsigned DW   = 8 * NUM_BYTES;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  if (NUM_BYTES == 0 || NUM_BYTES > MAX_BYTES) begin : g_bad_bytes
    $error("sub_bytes_pipe: NUM_BYTES must be 1..16");
  end
  if (PIPE_STAGES == 0 || PIPE_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("sub_bytes_pipe: PIPE_STAGES must be 1..3");
  end
  if (TAG_W == 0) begin : g_bad_tag
    $error("sub_bytes_pipe: TAG_W must be at least 1");
  end

  logic [PIPE_STAGES-1:0] r_valid;
  logic [DW-1:0]          r_data [PIPE_STAGES];
  logic [TAG_W-1:0]       r_tag  [PIPE_STAGES];
  logic [DW-1:0]          w_sub;
  logic [PIPE_STAGES-1:0] w_adv;
  logic                   w_accept;

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    sbox_lane u_lane (
      .i_mode (sbox_mode_e'(in_mode)),
      .i_byte (in_data[8*k +: 8]),
      .o_byte (w_sub[8*k +: 8])
    );
  end

  // A stage advances when any stage from it to the output has a hole, or the output drains.
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      w_adv[i] = out_ready;
      for (int j = i; j < PIPE_STAGES; j++) begin
        if (!r_valid[j]) w_adv[i] = 1'b1;
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign out_tag   = r_tag[LAST];
  assign busy      = |r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) begin
          r_data[0] <= w_sub;
          r_tag[0]  <= in_tag;
        end
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_data[i] <= r_data[i-1];
            r_tag[i]  <= r_tag[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed bench for sub_bytes_pipe: three configurations checked against hand values and a
// GF(2^8) reference model built independently of the design's tables.
module tb_sub_bytes_pipe;
  import aes_sbox_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in_data, a_out_data;
  logic [3:0]  a_in_tag, a_out_tag;

  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_in_tag, b_out_tag;

  logic         c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_busy;
  logic [127:0] c_in_data, c_out_data;
  logic [3:0]   c_in_tag, c_out_tag;

  sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(1), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag), .busy(a_busy)
  );

  sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(3), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy)
  );

  sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(1), .TAG_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_mode(c_in_mode), .in_data(c_in_data), .in_tag(c_in_tag), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag), .busy(c_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  logic        t3_mode [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] t3_data [4] = '{32'h000153FF, 32'h0063FF52, 32'h0063FF52, 32'h000153FF};
  logic [31:0] t3_exp  [4] = '{32'h637CED16, 32'h52007D48, 32'h63FB1600, 32'h5209507D};

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine transform.
  function automatic logic [7:0] model_fwd(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_word32(input logic mode, input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mode ? m_fwd[d[8*k +: 8]] : m_inv[d[8*k +: 8]];
    return r;
  endfunction

  task automatic xfer_c(input logic mode, input logic [127:0] d, input logic [3:0] tag,
                        output logic [127:0] q);
    int n;
    n = 0;
    c_in_valid = 1'b1;
    c_in_mode  = mode;
    c_in_data  = d;
    c_in_tag   = tag;
    @(negedge clk);
    c_in_valid = 1'b0;
    while (!c_out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("c_valid", c_out_valid, 1'b1);
    check("c_tag", c_out_tag, tag);
    q = c_out_data;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  tx_data [8];
    logic         tx_mode [8];
    logic [31:0]  tx_exp  [8];
    logic [127:0] d, q, qi;
    logic [31:0]  prev_data;
    logic [3:0]   prev_tag;
    logic         prev_stall, acc, emit;
    int           tx, rx, cyc;

    rst_n = 1'b0;
    {a_in_valid, a_in_mode, a_out_ready, a_in_data, a_in_tag} = '0;
    {b_in_valid, b_in_mode, b_out_ready, b_in_data, b_in_tag} = '0;
    {c_in_valid, c_in_mode, c_in_data, c_in_tag} = '0;
    c_out_ready = 1'b1;

    for (int x = 0; x < 256; x++) m_fwd[x] = model_fwd(8'(x));
    for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_out_data", a_out_data, 32'h0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    check("rst_b_busy", b_busy, 1'b0);
    check("rst_b_out_data", b_out_data, 32'h0);
    check("rst_c_out_valid", c_out_valid, 1'b0);
    check("rst_c_out_data", c_out_data, 128'h0);

    // Single inverse word, one-cycle latency
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_mode   = 1'b0;
    a_in_data   = 32'h0063FF52;
    a_in_tag    = 4'hA;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("t2_out_valid", a_out_valid, 1'b1);
    check("t2_out_data", a_out_data, 32'h52007D48);
    check("t2_out_tag", a_out_tag, 4'hA);
    check("t2_busy", a_busy, 1'b1);

    // Back-to-back alternating modes, one result per cycle
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        check("t3_out_valid", a_out_valid, 1'b1);
        check("t3_out_data", a_out_data, t3_exp[i-1]);
        check("t3_out_tag", a_out_tag, 4'(i));
      end
      if (i < 4) begin
        a_in_valid = 1'b1;
        a_in_mode  = t3_mode[i];
        a_in_data  = t3_data[i];
        a_in_tag   = 4'(i + 1);
        check("t3_in_ready", a_in_ready, 1'b1);
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("t3_idle", a_out_valid, 1'b0);

    // Three-stage stream of 8 words with a downstream stall on cycles 4-7
    for (int i = 0; i < 8; i++) begin
      tx_data[i] = 32'h10213243 + 32'(i) * 32'h0b0d0f11;
      tx_mode[i] = i[0];
      tx_exp[i]  = model_word32(tx_mode[i], tx_data[i]);
    end
    tx = 0;
    rx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_tag = '0;
    while (rx < 8 && cyc < 40) begin
      b_out_ready = !(cyc >= 4 && cyc <= 7);
      b_in_valid  = (tx < 8);
      if (tx < 8) begin
        b_in_data = tx_data[tx];
        b_in_mode = tx_mode[tx];
        b_in_tag  = 4'(tx);
      end
      #1;
      check("t4_in_ready", b_in_ready, ((tx - rx) < 3) || b_out_ready);
      if (prev_stall) begin
        check("t4_stall_valid", b_out_valid, 1'b1);
        check("t4_stall_data", b_out_data, prev_data);
        check("t4_stall_tag", b_out_tag, prev_tag);
      end
      prev_stall = b_out_valid && !b_out_ready;
      prev_data  = b_out_data;
      prev_tag   = b_out_tag;
      acc  = b_in_valid && b_in_ready;
      emit = b_out_valid && b_out_ready;
      if (emit) begin
        check("t4_data", b_out_data, tx_exp[rx]);
        check("t4_tag", b_out_tag, 4'(rx));
        rx++;
      end
      if (acc) tx++;
      @(negedge clk);
      cyc++;
    end
    b_in_valid = 1'b0;
    check("t4_count", rx, 8);
    check("t4_drained_valid", b_out_valid, 1'b0);
    check("t4_drained_busy", b_busy, 1'b0);

    // Full-state sweep of every byte value in both modes, plus inverse-then-forward
    for (int x = 0; x < 256; x++) begin
      check("pkg_fwd", sbox_fwd(8'(x)), m_fwd[x]);
      check("pkg_inv", sbox_inv(8'(x)), m_inv[x]);
    end
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * w + k);
      xfer_c(1'b1, d, 4'(w), q);
      for (int k = 0; k < 16; k++) check("t5_fwd", q[8*k +: 8], m_fwd[16*w + k]);
      xfer_c(1'b0, d, 4'(w), q);
      for (int k = 0; k < 16; k++) check("t5_inv", q[8*k +: 8], m_inv[16*w + k]);
      qi = q;
      xfer_c(1'b1, qi, 4'(w), q);
      check("t5_roundtrip", q, d);
    end

    // Reset with two words in flight
    b_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_in_valid = 1'b1;
      b_in_mode  = 1'b1;
      b_in_data  = 32'hA5A5A5A5 + 32'(i);
      b_in_tag   = 4'(i + 3);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", b_out_valid, 1'b1);
    check("t6_pre_busy", b_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_out_valid", b_out_valid, 1'b0);
    check("t6_busy", b_busy, 1'b0);
    check("t6_out_data", b_out_data, 32'h0);
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_emit", b_out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
